// File: rtl/ihm_display_seq.sv
// Sequential signed-number display driver: serial double-dabble conversion of a
// two's-complement value into registered seven-segment codes, sign and overflow.
module ihm_display_seq #(
    parameter int WIDTH          = 14,
    parameter int DIGITS         = 4,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic                  sig,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg
);

    // Decimal digits needed for the largest magnitude, 2^(WIDTH-1).
    function automatic int bcd_digits(input int w);
        logic [127:0] v;
        int           n;
        v = 128'd1 << (w - 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (v >= 128'd10) begin
                v = v / 128'd10;
                n = n + 1;
            end else begin
                v = v;
            end
        end
        return n;
    endfunction

    localparam int NB = bcd_digits(WIDTH);
    localparam int BW = 4 * NB;
    localparam int XN = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < NB; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low glyph codes, {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] c);
        return (SEG_ACTIVE_LOW != 0) ? c : ~c;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_r;
    logic                 neg_r;
    logic [WIDTH-1:0]     mag_r;
    logic [BW-1:0]        bcd_r;
    logic [CW-1:0]        cnt_r;

    logic [BW-1:0]        adj_s;
    logic [4*XN-1:0]      bcd_x_s;
    logic                 ovf_s;
    logic                 lead_s;
    logic [3:0]           nib_s;
    logic [6:0]           code_s;
    logic [7*DIGITS-1:0]  seg_s;

    assign adj_s   = dd_adjust(bcd_r);
    assign bcd_x_s = (4*XN)'(bcd_r);

    // Overflow whenever any BCD digit above the displayed ones is non-zero.
    always_comb begin
        ovf_s = 1'b0;
        for (int i = DIGITS; i < XN; i++) begin
            if (bcd_x_s[4*i +: 4] != 4'd0) begin
                ovf_s = 1'b1;
            end else begin
                ovf_s = ovf_s;
            end
        end
    end

    // Next display image, scanned from the top digit so leading zeros can be blanked.
    always_comb begin
        seg_s  = '0;
        lead_s = 1'b1;
        nib_s  = 4'd0;
        code_s = GLYPH_BLANK;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib_s = bcd_x_s[4*i +: 4];
            if (ovf_s) begin
                code_s = GLYPH_DASH;
            end else if ((BLANK_LZ != 0) && (i != 0) && lead_s && (nib_s == 4'd0)) begin
                code_s = GLYPH_BLANK;
            end else begin
                code_s = glyph(nib_s);
                lead_s = 1'b0;
            end
            seg_s[7*i +: 7] = seg_pol(code_s);
        end
    end

    // Control FSM with conversion datapath and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            neg_r   <= 1'b0;
            mag_r   <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sig     <= 1'b0;
            ovf     <= 1'b0;
            seg     <= {DIGITS{seg_pol(GLYPH_BLANK)}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        neg_r   <= din[WIDTH-1];
                        mag_r   <= din[WIDTH-1] ? (~din + WIDTH'(1)) : din;
                        bcd_r   <= '0;
                        cnt_r   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state_r <= S_SHIFT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    done           <= 1'b0;
                    {bcd_r, mag_r} <= {adj_s, mag_r} << 1;
                    cnt_r          <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    seg     <= seg_s;
                    sig     <= neg_r;
                    ovf     <= ovf_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ihm_display_seq.sv
// Scoreboard bench for ihm_display_seq: default, no-blanking and 16-bit instances.
module tb_ihm_display_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst16_n;
    logic        load_d, load_n, load16;
    logic [13:0] din_d, din_n;
    logic [15:0] din16;
    logic        busy_d, done_d, sig_d, ovf_d;
    logic        busy_n, done_n, sig_n, ovf_n;
    logic        busy_w, done_w, sig_w, ovf_w;
    logic [27:0] seg_d, seg_n, seg_w;

    ihm_display_seq u_def (
        .clk(clk), .rst_n(rst_n), .load(load_d), .din(din_d),
        .busy(busy_d), .done(done_d), .sig(sig_d), .ovf(ovf_d), .seg(seg_d)
    );

    ihm_display_seq #(.BLANK_LZ(0)) u_nlz (
        .clk(clk), .rst_n(rst_n), .load(load_n), .din(din_n),
        .busy(busy_n), .done(done_n), .sig(sig_n), .ovf(ovf_n), .seg(seg_n)
    );

    ihm_display_seq #(.WIDTH(16), .DIGITS(4)) u_w16 (
        .clk(clk), .rst_n(rst16_n), .load(load16), .din(din16),
        .busy(busy_w), .done(done_w), .sig(sig_w), .ovf(ovf_w), .seg(seg_w)
    );

    typedef struct {
        logic [27:0] seg;
        logic        sig;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [6:0]  BLANK7   = 7'b1111111;
    localparam logic [6:0]  DASH7    = 7'b0111111;
    localparam logic [27:0] ALLBLANK = 28'hFFFFFFF;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK7;
        endcase
    endfunction

    // Reference display built with decimal division.
    function automatic logic [27:0] model_seg(input int v, input bit blz);
        logic [27:0] r;
        int m, p;
        m = (v < 0) ? -v : v;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (m > 9999) r[7*i +: 7] = DASH7;
            else if (blz && i > 0 && m < p) r[7*i +: 7] = BLANK7;
            else r[7*i +: 7] = glyph((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic push_exp(input int v, input bit blz);
        exp_t e;
        e.seg = model_seg(v, blz);
        e.sig = (v < 0);
        e.ovf = (((v < 0) ? -v : v) > 9999);
        sb_q.push_back(e);
    endtask

    task automatic start(input int which, input int v);
        push_exp(v, which != 1);
        case (which)
            0: begin load_d = 1'b1; din_d = 14'(v); end
            1: begin load_n = 1'b1; din_n = 14'(v); end
            default: begin load16 = 1'b1; din16 = 16'(v); end
        endcase
        @(negedge clk);
        load_d = 1'b0; load_n = 1'b0; load16 = 1'b0;
    endtask

    // Waits for done; k_done counts negedges from the call (1 = now), -1 on timeout.
    task automatic wait_done(input int which, output int k_done, output int nbusy, output bit stable);
        logic [27:0] s0, s;
        logic        b, d;
        k_done = -1; nbusy = 0; stable = 1'b1;
        s0 = (which == 0) ? seg_d : (which == 1) ? seg_n : seg_w;
        for (int k = 1; k <= 60; k++) begin
            case (which)
                0: begin b = busy_d; d = done_d; s = seg_d; end
                1: begin b = busy_n; d = done_n; s = seg_n; end
                default: begin b = busy_w; d = done_w; s = seg_w; end
            endcase
            if (d) begin k_done = k; break; end
            if (b) nbusy++;
            if (s !== s0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; rst16_n = 1'b0;
        load_d = 1'b0; load_n = 1'b0; load16 = 1'b0;
        din_d = '0; din_n = '0; din16 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_d, done_d, sig_d, ovf_d} !== 4'b0000 || seg_d !== ALLBLANK) begin
            errors++;
            $display("FAIL reset_def: busy=%b done=%b sig=%b ovf=%b seg=%h, want 0 0 0 0 %h",
                     busy_d, done_d, sig_d, ovf_d, seg_d, ALLBLANK);
        end
        checks++;
        if (seg_n !== ALLBLANK || seg_w !== ALLBLANK || busy_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_other: seg_n=%h seg_w=%h busy_w=%b, want %h %h 0", seg_n, seg_w, busy_w, ALLBLANK, ALLBLANK);
        end
        rst_n = 1'b1; rst16_n = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (seg_d !== ALLBLANK || {busy_d, done_d, sig_d, ovf_d} !== 4'b0000) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_hold: seg=%h busy=%b done=%b, want constant reset values", seg_d, busy_d, done_d);
        end
    endtask

    task automatic test_values();
        int   vals[5] = '{1234, -8192, -1, 7, 0};
        int   k, nb;
        bit   st;
        exp_t e;
        foreach (vals[j]) begin
            start(0, vals[j]);
            wait_done(0, k, nb, st);
            e = sb_q.pop_front();
            checks++;
            if (k !== 16 || nb !== 15) begin
                errors++;
                $display("FAIL latency_%0d: done edge %0d busy cycles %0d, want 15 and 15", vals[j], k - 1, nb);
            end
            checks++;
            if (!st) begin
                errors++;
                $display("FAIL stable_%0d: seg changed before done, want unchanged", vals[j]);
            end
            checks++;
            if (seg_d !== e.seg || sig_d !== e.sig || ovf_d !== e.ovf) begin
                errors++;
                $display("FAIL value_%0d: seg=%h sig=%b ovf=%b, want seg=%h sig=%b ovf=%b",
                         vals[j], seg_d, sig_d, ovf_d, e.seg, e.sig, e.ovf);
            end
            @(negedge clk);
            checks++;
            if (done_d !== 1'b0 || busy_d !== 1'b0) begin
                errors++;
                $display("FAIL pulse_%0d: done=%b busy=%b one cycle later, want 0 0", vals[j], done_d, busy_d);
            end
        end
    endtask

    task automatic test_no_blank();
        int   vals[2] = '{7, -305};
        int   k, nb;
        bit   st;
        exp_t e;
        foreach (vals[j]) begin
            start(1, vals[j]);
            wait_done(1, k, nb, st);
            e = sb_q.pop_front();
            checks++;
            if (k !== 16 || seg_n !== e.seg || sig_n !== e.sig || ovf_n !== e.ovf) begin
                errors++;
                $display("FAIL noblank_%0d: k=%0d seg=%h sig=%b ovf=%b, want k=16 seg=%h sig=%b ovf=%b",
                         vals[j], k, seg_n, sig_n, ovf_n, e.seg, e.sig, e.ovf);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_handshake();
        int   k, nb, nd, n;
        int   t[3];
        bit   st;
        exp_t e;
        start(0, 42);
        repeat (4) @(negedge clk);
        load_d = 1'b1; din_d = 14'd99;
        @(negedge clk);
        load_d = 1'b0; din_d = 14'd0;
        wait_done(0, k, nb, st);
        e = sb_q.pop_front();
        checks++;
        if (k !== 11 || seg_d !== e.seg || sig_d !== e.sig) begin
            errors++;
            $display("FAIL ignore_busy_load: k=%0d seg=%h sig=%b, want k=11 seg=%h sig=%b", k, seg_d, sig_d, e.seg, e.sig);
        end
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_d || busy_d) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL not_queued: %0d busy/done cycles after ignored load, want 0", nd);
        end
        // Held load: three back-to-back conversions.
        repeat (3) push_exp(-56, 1'b1);
        load_d = 1'b1; din_d = 14'(-56);
        n = 0; t = '{0, 0, 0};
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done_d) begin
                t[n] = c;
                e = sb_q.pop_front();
                checks++;
                if (seg_d !== e.seg || sig_d !== e.sig) begin
                    errors++;
                    $display("FAIL b2b_value_%0d: seg=%h sig=%b, want seg=%h sig=%b", n, seg_d, sig_d, e.seg, e.sig);
                end
                n++;
                if (n == 3) begin load_d = 1'b0; break; end
            end
        end
        load_d = 1'b0;
        checks++;
        if (n !== 3 || t[1] - t[0] !== 16 || t[2] - t[1] !== 16) begin
            errors++;
            $display("FAIL b2b_period: pulses=%0d gaps %0d %0d, want 3 pulses gaps 16 16", n, t[1] - t[0], t[2] - t[1]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_d !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b after releasing load, want 0", busy_d);
        end
    endtask

    task automatic test_w16_overflow_reset();
        int   k, nb, nd;
        bit   st;
        exp_t e;
        start(2, 12345);
        wait_done(2, k, nb, st);
        e = sb_q.pop_front();
        checks++;
        if (k !== 18 || nb !== 17 || seg_w !== e.seg || ovf_w !== 1'b1 || sig_w !== 1'b0) begin
            errors++;
            $display("FAIL w16_ovf: k=%0d busy=%0d seg=%h ovf=%b sig=%b, want k=18 busy=17 seg=%h ovf=1 sig=0",
                     k, nb, seg_w, ovf_w, sig_w, e.seg);
        end
        @(negedge clk);
        load16 = 1'b1; din16 = 16'd300;
        @(negedge clk);
        load16 = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_w !== 1'b1) begin
            errors++;
            $display("FAIL w16_busy_before_abort: busy=%b, want 1", busy_w);
        end
        rst16_n = 1'b0;
        #1;
        checks++;
        if (seg_w !== ALLBLANK || {busy_w, done_w, sig_w, ovf_w} !== 4'b0000) begin
            errors++;
            $display("FAIL w16_abort: seg=%h busy=%b done=%b sig=%b ovf=%b, want %h 0 0 0 0",
                     seg_w, busy_w, done_w, sig_w, ovf_w, ALLBLANK);
        end
        @(negedge clk);
        rst16_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_w || seg_w !== ALLBLANK) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL w16_no_partial: %0d cycles with done or non-blank seg, want 0", nd);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_no_blank();
        test_handshake();
        test_w16_overflow_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
